ballot_sequencer: RTL and testbench

- Presiding-officer controller for the voting machine's tally datapath.
- Issues one vote per Ballot press and validates the one-hot candidate selection on IN.
- Strobes the per-candidate counter bank, enforces Close, and steps the display through Total/Result readout.
- Holds no per-candidate tallies; it drives increment/read selects into the existing counter bank and muxes its read data onto the display.

---
 rtl/ballot_sequencer_if.sv | 33 +++
 rtl/ballot_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_ballot_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ballot_sequencer_if.sv
// Panel buttons, voter selection and counter-bank signals of the ballot sequencer.
// The master side is the sequencer; the slave side is the panel and counter bank.
interface ballot_sequencer_if #(
   parameter int unsigned N_CAND = 4,
   parameter int unsigned DISP_W = 12
);
   localparam int unsigned SEL_W = (N_CAND > 1) ? $clog2(N_CAND) : 1;

   logic              Power;
   logic              Ballot;
   logic              Close;
   logic              Total;
   logic              Result;
   logic [N_CAND-1:0] IN;
   logic [DISP_W-1:0] rd_data;
   logic              inc_en;
   logic [N_CAND-1:0] inc_sel;
   logic [SEL_W-1:0]  rd_sel;
   logic              armed;
   logic              reject;
   logic              closed;
   logic [DISP_W-1:0] out;

   modport master (
      input  Power, Ballot, Close, Total, Result, IN, rd_data,
      output inc_en, inc_sel, rd_sel, armed, reject, closed, out
   );

   modport slave (
      output Power, Ballot, Close, Total, Result, IN, rd_data,
      input  inc_en, inc_sel, rd_sel, armed, reject, closed, out
   );
endinterface

// File: rtl/ballot_sequencer.sv
// Presiding-officer controller: issues ballots, validates one-hot selections, strobes the
// external counter bank, enforces poll close and drives the Total/Result display.
module ballot_sequencer #(
   parameter int unsigned N_CAND  = 4,
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned DISP_W  = 12
) (
   input logic                clk,
   input logic                Clear,
   ballot_sequencer_if.master bus
);
   localparam int unsigned SEL_W = (N_CAND > 1) ? $clog2(N_CAND) : 1;
   localparam int unsigned TW    = $clog2(TIMEOUT) + 1;

   typedef enum logic [2:0] {StOff, StIdle, StArmed, StWaitRel, StClosed, StResult} state_e;

   state_e            state_q, state_d;
   logic              ballot_prev_q, close_prev_q, total_prev_q, result_prev_q;
   logic              ballot_rise, close_rise, total_rise, result_rise;
   logic [TW-1:0]     timer_q, timer_d;
   logic [DISP_W-1:0] votes_q, votes_d;
   logic [DISP_W-1:0] ballots_q, ballots_d;
   logic [DISP_W-1:0] out_q, out_d;
   logic              closed_flag_q, closed_flag_d;
   logic              close_pend_q, close_pend_d;
   logic              show_rd_q, show_rd_d;
   logic [SEL_W-1:0]  rd_sel_q, rd_sel_d;
   logic              inc_en_q, inc_en_d;
   logic              reject_q, reject_d;
   logic [N_CAND-1:0] inc_sel_q, inc_sel_d;
   logic              sel_none, sel_one, ballot_done;

   assign ballot_rise = bus.Ballot & ~ballot_prev_q;
   assign close_rise  = bus.Close & ~close_prev_q;
   assign total_rise  = bus.Total & ~total_prev_q;
   assign result_rise = bus.Result & ~result_prev_q;

   assign sel_none = (bus.IN == '0);
   assign sel_one  = !sel_none && ((bus.IN & (bus.IN - N_CAND'(1))) == '0);

   always_comb begin
      state_d       = state_q;
      timer_d       = timer_q;
      votes_d       = votes_q;
      ballots_d     = ballots_q;
      closed_flag_d = closed_flag_q;
      close_pend_d  = close_pend_q;
      show_rd_d     = show_rd_q;
      rd_sel_d      = rd_sel_q;
      inc_en_d      = 1'b0;
      inc_sel_d     = '0;
      reject_d      = 1'b0;
      ballot_done   = 1'b0;
      // In read mode the display follows the bank one clock behind rd_sel.
      out_d         = (state_q == StResult && show_rd_q) ? bus.rd_data : out_q;

      if (!bus.Power) begin
         state_d       = StOff;
         timer_d       = '0;
         close_pend_d  = 1'b0;
         closed_flag_d = closed_flag_q | close_pend_q;
         show_rd_d     = 1'b0;
         rd_sel_d      = '0;
         out_d         = '0;
      end else begin
         case (state_q)
            StOff: state_d = closed_flag_q ? StClosed : StIdle;
            StIdle: begin
               if (close_rise) begin
                  state_d       = StClosed;
                  closed_flag_d = 1'b1;
               end else if (ballot_rise) begin
                  state_d = StArmed;
                  timer_d = '0;
                  if (ballots_q != '1) ballots_d = ballots_q + DISP_W'(1);
               end
               if (total_rise) begin
                  out_d     = votes_q;
                  show_rd_d = 1'b0;
               end
            end
            StArmed: begin
               if (close_rise) close_pend_d = 1'b1;
               if (sel_none) begin
                  if (timer_q == TW'(TIMEOUT - 1)) begin
                     reject_d    = 1'b1;
                     ballot_done = 1'b1;
                  end else begin
                     timer_d = timer_q + TW'(1);
                  end
               end else if (sel_one) begin
                  inc_en_d  = 1'b1;
                  inc_sel_d = bus.IN;
                  state_d   = StWaitRel;
                  if (votes_q != '1) votes_d = votes_q + DISP_W'(1);
               end else begin
                  reject_d = 1'b1;
                  state_d  = StWaitRel;
               end
            end
            StWaitRel: begin
               if (close_rise) close_pend_d = 1'b1;
               if (sel_none) ballot_done = 1'b1;
            end
            StClosed: begin
               if (result_rise) begin
                  state_d   = StResult;
                  rd_sel_d  = '0;
                  show_rd_d = 1'b1;
               end else if (total_rise) begin
                  out_d     = votes_q;
                  show_rd_d = 1'b0;
               end
            end
            StResult: begin
               if (result_rise) begin
                  rd_sel_d  = (rd_sel_q == SEL_W'(N_CAND - 1)) ? '0 : rd_sel_q + SEL_W'(1);
                  show_rd_d = 1'b1;
               end else if (total_rise) begin
                  out_d     = votes_q;
                  show_rd_d = 1'b0;
               end
            end
            default: state_d = StIdle;
         endcase

         // A close requested mid-ballot takes effect as soon as the ballot finishes.
         if (ballot_done) begin
            if (close_pend_q || close_rise) begin
               state_d       = StClosed;
               closed_flag_d = 1'b1;
               close_pend_d  = 1'b0;
            end else begin
               state_d = StIdle;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (Clear) begin
         state_q       <= StIdle;
         ballot_prev_q <= 1'b0;
         close_prev_q  <= 1'b0;
         total_prev_q  <= 1'b0;
         result_prev_q <= 1'b0;
         timer_q       <= '0;
         votes_q       <= '0;
         ballots_q     <= '0;
         out_q         <= '0;
         closed_flag_q <= 1'b0;
         close_pend_q  <= 1'b0;
         show_rd_q     <= 1'b0;
         rd_sel_q      <= '0;
         inc_en_q      <= 1'b0;
         inc_sel_q     <= '0;
         reject_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         ballot_prev_q <= bus.Ballot;
         close_prev_q  <= bus.Close;
         total_prev_q  <= bus.Total;
         result_prev_q <= bus.Result;
         timer_q       <= timer_d;
         votes_q       <= votes_d;
         ballots_q     <= ballots_d;
         out_q         <= out_d;
         closed_flag_q <= closed_flag_d;
         close_pend_q  <= close_pend_d;
         show_rd_q     <= show_rd_d;
         rd_sel_q      <= rd_sel_d;
         inc_en_q      <= inc_en_d;
         inc_sel_q     <= inc_sel_d;
         reject_q      <= reject_d;
      end
   end

   assign bus.inc_en  = inc_en_q;
   assign bus.inc_sel = inc_sel_q;
   assign bus.rd_sel  = rd_sel_q;
   assign bus.armed   = (state_q == StArmed);
   assign bus.reject  = reject_q;
   assign bus.closed  = (state_q == StClosed) || (state_q == StResult);
   assign bus.out     = out_q;

   // Every counted vote was issued on a ballot first.
   assert property (@(posedge clk) disable iff (Clear) ballots_q >= votes_q);
endmodule

// File: tb/tb_ballot_sequencer.sv
// Directed bench for ballot_sequencer: per-clock vector table plus hand-written corner cases,
// with a small behavioural counter bank feeding rd_data.
module tb_ballot_sequencer;
   logic clk = 1'b0;
   logic Clear;

   ballot_sequencer_if #(.N_CAND(4), .DISP_W(12)) bus ();

   ballot_sequencer #(.N_CAND(4), .TIMEOUT(16), .DISP_W(12)) dut (
      .clk  (clk),
      .Clear(Clear),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   logic [11:0] bank [4];
   always @(posedge clk) begin
      if (Clear) begin
         for (int i = 0; i < 4; i++) bank[i] <= '0;
      end else if (bus.inc_en) begin
         for (int i = 0; i < 4; i++)
            if (bus.inc_sel[i] && bank[i] != 12'hFFF) bank[i] <= bank[i] + 12'd1;
      end
   end
   assign bus.rd_data = bank[bus.rd_sel];

   typedef struct {
      logic        pwr, bal, cls, tot, res;
      logic [3:0]  in;
      logic [21:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   errors = 0;
   int   checks = 0;
   int   hit;

   // Packed view {armed, inc_en, inc_sel, reject, closed, rd_sel, out}.
   function automatic logic [21:0] snap();
      return {bus.armed, bus.inc_en, bus.inc_sel, bus.reject, bus.closed, bus.rd_sel, bus.out};
   endfunction

   task automatic add(input logic p, b, c, t, r, input logic [3:0] in,
                      input logic a, i, input logic [3:0] sel, input logic j, cl,
                      input logic [1:0] rd, input logic [11:0] o);
      vec_t v;
      v.pwr = p; v.bal = b; v.cls = c; v.tot = t; v.res = r; v.in = in;
      v.exp = {a, i, sel, j, cl, rd, o};
      vecs.push_back(v);
   endtask

   task automatic drive(input logic p, b, c, t, r, input logic [3:0] in);
      bus.Power = p; bus.Ballot = b; bus.Close = c; bus.Total = t; bus.Result = r; bus.IN = in;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // One valid vote with IN held four clocks, then release.
      add(1,1,0,0,0,4'b0000, 1,0,4'b0000,0,0,0,0);
      add(1,0,0,0,0,4'b0001, 0,1,4'b0001,0,0,0,0);
      for (int k = 0; k < 3; k++) add(1,0,0,0,0,4'b0001, 0,0,0,0,0,0,0);
      add(1,0,0,0,0,4'b0000, 0,0,0,0,0,0,0);
      // Multi-bit selections are rejected.
      add(1,1,0,0,0,4'b0000, 1,0,0,0,0,0,0);
      add(1,0,0,0,0,4'b0101, 0,0,0,1,0,0,0);
      add(1,0,0,0,0,4'b0000, 0,0,0,0,0,0,0);
      add(1,1,0,0,0,4'b0000, 1,0,0,0,0,0,0);
      add(1,0,0,0,0,4'b1111, 0,0,0,1,0,0,0);
      add(1,0,0,0,0,4'b0000, 0,0,0,0,0,0,0);
      // Changing selection without release counts once.
      add(1,1,0,0,0,4'b0000, 1,0,0,0,0,0,0);
      add(1,0,0,0,0,4'b0001, 0,1,4'b0001,0,0,0,0);
      add(1,0,0,0,0,4'b0010, 0,0,0,0,0,0,0);
      add(1,0,0,0,0,4'b0000, 0,0,0,0,0,0,0);
      // Votes 3 and 4.
      add(1,1,0,0,0,4'b0000, 1,0,0,0,0,0,0);
      add(1,0,0,0,0,4'b0010, 0,1,4'b0010,0,0,0,0);
      add(1,0,0,0,0,4'b0000, 0,0,0,0,0,0,0);
      add(1,1,0,0,0,4'b0000, 1,0,0,0,0,0,0);
      add(1,0,0,0,0,4'b0100, 0,1,4'b0100,0,0,0,0);
      add(1,0,0,0,0,4'b0000, 0,0,0,0,0,0,0);
      // Vote 5 with Close pressed while armed; poll closes on release.
      add(1,1,0,0,0,4'b0000, 1,0,0,0,0,0,0);
      add(1,0,1,0,0,4'b0000, 1,0,0,0,0,0,0);
      add(1,0,0,0,0,4'b0100, 0,1,4'b0100,0,0,0,0);
      add(1,0,0,0,0,4'b0000, 0,0,0,0,1,0,0);
      add(1,1,0,0,0,4'b0000, 0,0,0,0,1,0,0);
      add(1,0,0,0,0,4'b0001, 0,0,0,0,1,0,0);
      // Total, then Result readout: bank = {2,1,2,0}.
      add(1,0,0,1,0,4'b0000, 0,0,0,0,1,0,5);
      add(1,0,0,0,0,4'b0000, 0,0,0,0,1,0,5);
      add(1,0,0,0,1,4'b0000, 0,0,0,0,1,0,5);
      add(1,0,0,0,0,4'b0000, 0,0,0,0,1,0,2);
      add(1,0,0,0,1,4'b0000, 0,0,0,0,1,1,2);
      add(1,0,0,0,0,4'b0000, 0,0,0,0,1,1,1);
      add(1,0,0,0,1,4'b0000, 0,0,0,0,1,2,1);
      add(1,0,0,0,0,4'b0000, 0,0,0,0,1,2,2);
      add(1,0,0,0,1,4'b0000, 0,0,0,0,1,3,2);
      add(1,0,0,0,0,4'b0000, 0,0,0,0,1,3,0);
      add(1,0,0,0,1,4'b0000, 0,0,0,0,1,0,0);
      add(1,0,0,0,0,4'b0000, 0,0,0,0,1,0,2);
      // Result beats Total; then Total alone returns to show-total.
      add(1,0,0,1,1,4'b0000, 0,0,0,0,1,1,2);
      add(1,0,0,0,0,4'b0000, 0,0,0,0,1,1,1);
      add(1,0,0,1,0,4'b0000, 0,0,0,0,1,1,5);
      add(1,0,0,0,0,4'b0000, 0,0,0,0,1,1,5);
      // Power cycle keeps the closed flag and vote count.
      add(0,0,0,0,0,4'b0000, 0,0,0,0,0,0,0);
      add(1,0,0,0,0,4'b0000, 0,0,0,0,1,0,0);
      add(1,0,0,1,0,4'b0000, 0,0,0,0,1,0,5);
      add(1,0,0,0,0,4'b0000, 0,0,0,0,1,0,5);

      Clear = 1'b1;
      drive(1,0,0,0,0,4'b0000);
      step();
      step();
      check("reset", 32'(snap()), 32'h0);
      Clear = 1'b0;

      for (int k = 0; k < vecs.size(); k++) begin
         drive(vecs[k].pwr, vecs[k].bal, vecs[k].cls, vecs[k].tot, vecs[k].res, vecs[k].in);
         step();
         check($sformatf("vec%0d", k), 32'(snap()), 32'(vecs[k].exp));
      end

      // Clear from CLOSED, then Clear mid-ARMED.
      drive(1,0,0,0,0,4'b0000);
      Clear = 1'b1;
      step();
      check("clear_from_closed", 32'(snap()), 32'h0);
      Clear = 1'b0;
      drive(1,1,0,0,0,4'b0000);
      step();
      check("arm_after_clear", 32'(snap()), 32'h20_0000);
      drive(1,0,0,0,0,4'b0000);
      step();
      Clear = 1'b1;
      step();
      check("clear_mid_armed", 32'(snap()), 32'h0);
      Clear = 1'b0;

      // Timeout: reject arrives on the 16th clock after arming.
      drive(1,1,0,0,0,4'b0000);
      step();
      drive(1,0,0,0,0,4'b0000);
      hit = 0;
      for (int k = 1; k <= 20 && hit == 0; k++) begin
         step();
         if (bus.reject === 1'b1) hit = k;
      end
      check("timeout_cycle", 32'(hit), 32'd16);
      check("timeout_disarm", 32'(bus.armed), 32'd0);
      step();
      drive(1,1,0,0,0,4'b0000);
      step();
      check("arm_after_timeout", 32'(snap()), 32'h20_0000);
      drive(1,0,0,0,0,4'b1000);
      step();
      check("vote_after_timeout", 32'(snap()), 32'h18_0000);
      drive(1,0,0,0,0,4'b0000);
      step();

      // Close beats Ballot in IDLE; Total then shows the single vote.
      drive(1,1,1,0,0,4'b0000);
      step();
      check("close_beats_ballot", 32'(snap()), 32'h4000);
      drive(1,0,0,1,0,4'b0000);
      step();
      check("total_after_clear", 32'(snap()), 32'h4001);
      drive(1,0,0,0,0,4'b0000);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
